// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: boot controller for the MIPS32 pipeline.
// Holds the core and zeroes its register file. It then streams a program
// into instruction/data memory and releases the core from PC 0. Completion
// is reported when the core halts or when the RUN cycle budget runs out.
module mips32_prog_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [31:0]       rf_wdata,
  output logic              core_hold,
  output logic              pc_load,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS   = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [31:0]     RUN_LAST    = 32'(TIMEOUT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_last;
  logic                r_zero_len;
  logic [4:0]          r_clear_idx;
  logic [31:0]         r_run_cycles;
  logic                r_timed_out;

  logic                w_hs;
  logic [ADDR_W:0]     w_len;

  // Program length clamped to the memory size, so the write pointer never wraps.
  assign w_len = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  // A word transfers only in LOAD and never while reset is asserted.
  assign w_hs  = in_valid & in_ready;

  // Boot sequencer: IDLE -> CLEAR -> LOAD -> RELEASE -> RUN -> DONE.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_last       <= '0;
      r_zero_len   <= 1'b0;
      r_clear_idx  <= '0;
      r_run_cycles <= '0;
      r_timed_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_CLEAR;
            r_last       <= ADDR_W'(w_len - (ADDR_W+1)'(1));
            r_zero_len   <= (w_len == '0);
            r_wr_ptr     <= '0;
            r_clear_idx  <= '0;
            r_run_cycles <= '0;
            r_timed_out  <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_clear_idx <= r_clear_idx + 5'd1;
          if (r_clear_idx == 5'd31) begin
            r_state <= r_zero_len ? S_RELEASE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            // The last word leaves the pointer in place rather than wrapping it.
            if (r_wr_ptr == r_last) begin
              r_state <= S_RELEASE;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
          end
        end
        S_RELEASE: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_run_cycles <= r_run_cycles + 32'd1;
          if (core_halted) begin
            r_state     <= S_DONE;
            r_timed_out <= 1'b0;
          end else if (r_run_cycles == RUN_LAST) begin
            r_state     <= S_DONE;
            r_timed_out <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decodes. The strobes are also gated by rst to block any write in a reset cycle.
  assign in_ready   = (r_state == S_LOAD) & ~rst;
  assign mem_we     = w_hs;
  assign mem_addr   = r_wr_ptr;
  assign mem_wdata  = w_hs ? in_data : '0;
  assign rf_we      = (r_state == S_CLEAR) & ~rst;
  assign rf_addr    = r_clear_idx;
  assign rf_wdata   = '0;
  assign core_hold  = (r_state != S_RUN);
  assign pc_load    = (r_state == S_RELEASE) & ~rst;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign timed_out  = r_timed_out;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed testbench for mips32_prog_loader (ADDR_W=10, TIMEOUT=16).
module tb_mips32_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk1;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              rf_we;
  logic [4:0]        rf_addr;
  logic [31:0]       rf_wdata;
  logic              core_hold;
  logic              pc_load;
  logic              core_halted;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [31:0]       run_cycles;

  int checks = 0;
  int errors = 0;

  logic [31:0] boot_words [5] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                                  32'h00000000, 32'h00222000};
  logic [31:0] bp_words   [3] = '{32'hdeadbeef, 32'h12345678, 32'hcafef00d};

  mips32_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk1(clk1), .rst(rst), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .core_hold(core_hold), .pc_load(pc_load), .core_halted(core_halted),
    .busy(busy), .done(done), .timed_out(timed_out), .run_cycles(run_cycles)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle; returns shortly after the rising edge.
  task automatic tick();
    @(posedge clk1);
    #2;
  endtask

  // Pulse start with a given length; returns in CLEAR cycle 1.
  task automatic pulse_start(input int n);
    num_words = (ADDR_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From CLEAR cycle 1 to cycle 33.
  task automatic skip_clear();
    repeat (32) tick();
  endtask

  // Halt the core in the current RUN cycle.
  task automatic finish_run();
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    #1;
    checks++; if (rf_we !== 1'b0 || mem_we !== 1'b0 || pc_load !== 1'b0) begin
      errors++; $display("FAIL rst_strobes got rf_we=%b mem_we=%b pc_load=%b exp 0", rf_we, mem_we, pc_load);
    end
    rst = 1'b0;
    #1;
    checks++; if (core_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_idle got hold=%b busy=%b done=%b rdy=%b exp 1000", core_hold, busy, done, in_ready);
    end
    // Reset in the middle of LOAD.
    pulse_start(5);
    skip_clear();
    in_valid = 1'b1; in_data = 32'h11111111;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd0) begin
      errors++; $display("FAIL rst_preload got we=%b addr=%0d exp 1 0", mem_we, mem_addr);
    end
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_cycle_write got we=%b rdy=%b exp 0 0", mem_we, in_ready);
    end
    repeat (3) begin
      tick(); #1;
      checks++; if (mem_we !== 1'b0) begin
        errors++; $display("FAIL rst_hold_write got we=%b exp 0", mem_we);
      end
    end
    rst = 1'b0;
    #1;
    checks++; if (core_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || rf_we !== 1'b0 ||
                  pc_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL rst_flags got hold=%b rdy=%b we=%b rfwe=%b pcl=%b busy=%b done=%b to=%b exp 10000000",
                         core_hold, in_ready, mem_we, rf_we, pc_load, busy, done, timed_out);
    end
    checks++; if (run_cycles !== 32'd0 || mem_addr !== 10'd0 || rf_addr !== 5'd0) begin
      errors++; $display("FAIL rst_values got rc=%0d maddr=%0d raddr=%0d exp 0 0 0", run_cycles, mem_addr, rf_addr);
    end
    tick(); #1;
    checks++; if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_idle_valid got we=%b exp 0", mem_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_boot();
    pulse_start(5);
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (rf_we !== 1'b1 || rf_addr !== 5'(i) || rf_wdata !== 32'd0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL boot_clear i=%0d got we=%b addr=%0d data=%h rdy=%b exp 1 %0d 0 0",
                           i, rf_we, rf_addr, rf_wdata, in_ready, i);
      end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = boot_words[k];
      #1;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 10'(k) || mem_wdata !== boot_words[k]) begin
        errors++; $display("FAIL boot_write k=%0d got we=%b addr=%0d data=%h exp 1 %0d %h",
                           k, mem_we, mem_addr, mem_wdata, k, boot_words[k]);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (pc_load !== 1'b1 || core_hold !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL boot_release got pcl=%b hold=%b rdy=%b exp 1 1 0", pc_load, core_hold, in_ready);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (core_hold !== 1'b0 || pc_load !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL boot_run i=%0d got hold=%b pcl=%b done=%b exp 0 0 0", i, core_hold, pc_load, done);
      end
      tick();
    end
    finish_run();
    #1;
    checks++; if (done !== 1'b1 || timed_out !== 1'b0 || run_cycles !== 32'd11 || busy !== 1'b0) begin
      errors++; $display("FAIL boot_done got done=%b to=%b rc=%0d busy=%b exp 1 0 11 0", done, timed_out, run_cycles, busy);
    end
  endtask

  task automatic test_backpressure();
    int nw;
    pulse_start(3);
    skip_clear();
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready got %b exp 1", in_ready);
    end
    nw = 0;
    for (int c = 0; c < 20 && nw < 3; c++) begin
      in_valid = c[0];
      in_data  = bp_words[nw];
      #1;
      if (c[0]) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 10'(nw) || mem_wdata !== bp_words[nw]) begin
          errors++; $display("FAIL bp_write n=%0d got we=%b addr=%0d data=%h exp 1 %0d %h",
                             nw, mem_we, mem_addr, mem_wdata, nw, bp_words[nw]);
        end
        nw++;
      end else begin
        checks++; if (mem_we !== 1'b0) begin
          errors++; $display("FAIL bp_idle c=%0d got we=%b exp 0", c, mem_we);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (pc_load !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release got pcl=%b rdy=%b exp 1 0", pc_load, in_ready);
    end
    tick();
    finish_run();
  endtask

  task automatic test_zero_len();
    int rdy_seen;
    rdy_seen = 0;
    pulse_start(0);
    for (int i = 0; i < 32; i++) begin
      #1;
      if (in_ready === 1'b1) rdy_seen++;
      tick();
    end
    #1;
    checks++; if (pc_load !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL zero_release got pcl=%b rdy=%b exp 1 0", pc_load, in_ready);
    end
    checks++; if (rdy_seen !== 0) begin
      errors++; $display("FAIL zero_ready got %0d ready cycles exp 0", rdy_seen);
    end
    tick(); #1;
    checks++; if (core_hold !== 1'b0) begin
      errors++; $display("FAIL zero_run got hold=%b exp 0", core_hold);
    end
    finish_run();
  endtask

  task automatic test_timeout();
    pulse_start(0);
    skip_clear();
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (done !== 1'b0 || core_hold !== 1'b0) begin
        errors++; $display("FAIL to_run i=%0d got done=%b hold=%b exp 0 0", i, done, core_hold);
      end
      tick();
    end
    #1;
    checks++; if (done !== 1'b1 || timed_out !== 1'b1 || run_cycles !== 32'd16 || core_hold !== 1'b1) begin
      errors++; $display("FAIL to_done got done=%b to=%b rc=%0d hold=%b exp 1 1 16 1", done, timed_out, run_cycles, core_hold);
    end
    tick(); #1;
    checks++; if (done !== 1'b1 || timed_out !== 1'b1 || run_cycles !== 32'd16) begin
      errors++; $display("FAIL to_hold got done=%b to=%b rc=%0d exp 1 1 16", done, timed_out, run_cycles);
    end
  endtask

  task automatic test_restart();
    pulse_start(2);
    #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || run_cycles !== 32'd0 || timed_out !== 1'b0 ||
                  rf_we !== 1'b1 || rf_addr !== 5'd0) begin
      errors++; $display("FAIL rs_clear got busy=%b done=%b rc=%0d to=%b rfwe=%b raddr=%0d exp 1 0 0 0 1 0",
                         busy, done, run_cycles, timed_out, rf_we, rf_addr);
    end
    skip_clear();
    in_valid = 1'b1; in_data = 32'haaaa0001;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd0) begin
      errors++; $display("FAIL rs_word0 got we=%b addr=%0d exp 1 0", mem_we, mem_addr);
    end
    tick();
    in_valid = 1'b0; start = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rs_stall got we=%b exp 0", mem_we);
    end
    tick();
    start = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rs_ignored got rdy=%b rfwe=%b busy=%b exp 1 0 1", in_ready, rf_we, busy);
    end
    in_valid = 1'b1; in_data = 32'haaaa0002;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 32'haaaa0002) begin
      errors++; $display("FAIL rs_word1 got we=%b addr=%0d data=%h exp 1 1 aaaa0002", mem_we, mem_addr, mem_wdata);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (pc_load !== 1'b1) begin
      errors++; $display("FAIL rs_release got pcl=%b exp 1", pc_load);
    end
    tick();
    finish_run();
    #1;
    checks++; if (done !== 1'b1 || timed_out !== 1'b0 || run_cycles !== 32'd1) begin
      errors++; $display("FAIL rs_done got done=%b to=%b rc=%0d exp 1 0 1", done, timed_out, run_cycles);
    end
  endtask

  task automatic test_halt_at_timeout();
    pulse_start(0);
    skip_clear();
    tick();
    repeat (15) tick();
    finish_run();
    #1;
    checks++; if (done !== 1'b1 || timed_out !== 1'b0 || run_cycles !== 32'd16) begin
      errors++; $display("FAIL hat_done got done=%b to=%b rc=%0d exp 1 0 16", done, timed_out, run_cycles);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0;
    in_data = '0; core_halted = 1'b0;
    test_reset();
    test_basic_boot();
    test_backpressure();
    test_zero_len();
    test_timeout();
    test_restart();
    test_halt_at_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
